// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared constants for the boot-time instruction-memory loader: the loader
// state encoding, the frame length-field width and a small helper that
// tells whether a state accepts stream bytes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CSUM state).
package imem_loader_pkg;

   localparam int LEN_WIDTH = 16;

   typedef enum logic [2:0] {
      LOADER_LEN_HI = 3'd0,
      LOADER_LEN_LO = 3'd1,
      LOADER_DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
      LOADER_CSUM   = 3'd3,
`endif
      LOADER_FLUSH  = 3'd4,
      LOADER_DONE   = 3'd5,
      LOADER_ERR    = 3'd6
   } loaderState_e;

   // States in which the loader takes a byte off the stream.
   function automatic logic acceptsBytes(input loaderState_e s);
      logic ok;
      ok = (s == LOADER_LEN_HI) || (s == LOADER_LEN_LO) || (s == LOADER_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
      ok = ok || (s == LOADER_CSUM);
`endif
      return ok;
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
// Shifts stream bytes into a big-endian 32-bit word and tracks the byte
// lane. When the fourth byte of a word arrives, word_valid_o pulses in the
// same cycle with word_o holding the full word (first byte in bits 31:24).
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   byte_valid_i  a data byte is being consumed this cycle
//   byte_i        the data byte
//   word_valid_o  this byte completes a word
//   word_o        the completed word (meaningful while word_valid_o is high)
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [23:0] shift_q;
   logic [1:0]  lane_q;

   // Keep the three most recent bytes; the lane counter wraps 3->0 exactly
   // when a word completes, so a reset mid-word drops the partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         lane_q  <= '0;
      end else if (byte_valid_i) begin
         shift_q <= {shift_q[15:0], byte_i};
         lane_q  <= lane_q + 2'd1;
      end
   end

   assign word_valid_o = byte_valid_i && (lane_q == 2'd3);
   assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time instruction-memory loader. Accepts a framed byte stream
// (16-bit big-endian word count N, N big-endian words, optional checksum
// byte), writes the words to imem from byte address 0 and holds the CPU in
// reset until the whole image has landed.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- require a trailing
// byte equal to the XOR of all data bytes.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_byte/in_valid      stream byte and its valid
//   in_ready              loader can take a byte this cycle
//   imem_we/addr/wdata    registered one-cycle word write to imem
//   cpu_rst_n             processor reset, released only once loaded
//   done / error          image loaded / load rejected (terminal)
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            in_byte,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rst_n,
   output logic                  done,
   output logic                  error
);

   localparam logic [LEN_WIDTH-1:0]  MAX_LEN = LEN_WIDTH'(MAX_WORDS);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE = 1;
   localparam logic [ADDR_WIDTH-3:0] IDX_ONE = 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam loaderState_e AFTER_DATA = LOADER_CSUM;
`else
   localparam loaderState_e AFTER_DATA = LOADER_FLUSH;
`endif

   loaderState_e          state_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [ADDR_WIDTH-3:0] wordIdx_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q;
`endif

   logic                 accept;
   logic                 dataAccept;
   logic                 wordValid;
   logic [31:0]          word;
   logic [LEN_WIDTH-1:0] lenFull;
   logic                 lastWord;

   assign in_ready   = acceptsBytes(state_q);
   assign accept     = in_valid && in_ready;
   assign dataAccept = accept && (state_q == LOADER_DATA);
   assign lenFull    = {len_q[LEN_WIDTH-1:8], in_byte};
   assign lastWord   = (LEN_WIDTH'(wordIdx_q) == (len_q - LEN_ONE));

   byte_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .byte_valid_i (dataAccept),
      .byte_i       (in_byte),
      .word_valid_o (wordValid),
      .word_o       (word)
   );

   // Loader FSM together with the registered write port, word counter and
   // checksum accumulator. The write for a word is registered on the edge
   // that accepts its fourth byte, so it reaches memory one edge later;
   // that same edge moves FLUSH to DONE, so the CPU leaves reset only after
   // the final word has been written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LOADER_LEN_HI;
         len_q     <= '0;
         wordIdx_q <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         we_q <= 1'b0;
         if (wordValid) begin
            we_q      <= 1'b1;
            addr_q    <= {wordIdx_q, 2'b00};
            wdata_q   <= word;
            wordIdx_q <= wordIdx_q + IDX_ONE;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (dataAccept) begin
            csum_q <= csum_q ^ in_byte;
         end
`endif
         unique case (state_q)
            LOADER_LEN_HI: begin
               if (accept) begin
                  len_q   <= {in_byte, 8'h00};
                  state_q <= LOADER_LEN_LO;
               end
            end
            LOADER_LEN_LO: begin
               if (accept) begin
                  len_q <= lenFull;
                  if (lenFull > MAX_LEN) begin
                     state_q <= LOADER_ERR;
                  end else if (lenFull == '0) begin
                     state_q <= AFTER_DATA;
                  end else begin
                     state_q <= LOADER_DATA;
                  end
               end
            end
            LOADER_DATA: begin
               if (wordValid && lastWord) begin
                  state_q <= AFTER_DATA;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LOADER_CSUM: begin
               if (accept) begin
                  state_q <= (in_byte == csum_q) ? LOADER_FLUSH : LOADER_ERR;
               end
            end
`endif
            LOADER_FLUSH: state_q <= LOADER_DONE;
            LOADER_DONE:  state_q <= LOADER_DONE;
            LOADER_ERR:   state_q <= LOADER_ERR;
            default:      state_q <= LOADER_ERR;
         endcase
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign done       = (state_q == LOADER_DONE);
   assign error      = (state_q == LOADER_ERR);
   assign cpu_rst_n  = (state_q == LOADER_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader: directed frames from the bring-up
// list plus randomized frames, compared against a frame-level reference
// model (list of expected writes and the expected final status).
module tb_imem_loader;

   localparam int ADDR_WIDTH = 10;
   localparam int MAX_WORDS  = 256;

   logic                  clk;
   logic                  rst_n;
   logic [7:0]            in_byte;
   logic                  in_valid;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic                  cpu_rst_n;
   logic                  done;
   logic                  error;

   int checks;
   int errors;

   logic [ADDR_WIDTH-1:0] gotAddr[$];
   logic [31:0]           gotData[$];
   logic [31:0]           frameWords[$];

   imem_loader #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MAX_WORDS  (MAX_WORDS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_byte    (in_byte),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .done       (done),
      .error      (error)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record every memory write strobe, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && imem_we) begin
         gotAddr.push_back(imem_addr);
         gotData.push_back(imem_wdata);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_we"},     32'(imem_we),    32'd0);
      checkOutput({tag, "_addr"},   32'(imem_addr),  32'd0);
      checkOutput({tag, "_wdata"},  imem_wdata,      32'd0);
      checkOutput({tag, "_cpurst"}, 32'(cpu_rst_n),  32'd0);
      checkOutput({tag, "_done"},   32'(done),       32'd0);
      checkOutput({tag, "_error"},  32'(error),      32'd0);
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      gotAddr.delete();
      gotData.delete();
   endtask

   // Present one byte until accepted (bounded); optional idle cycle first.
   task automatic applyStimulus(input logic [7:0] b, input bit gap, input string tag);
      bit acc;
      int budget;
      acc    = 1'b0;
      budget = 0;
      if (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      while (!acc && budget < 20) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_byte  = b;
         acc      = in_ready;
         @(posedge clk);
         budget++;
      end
      if (!acc) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic makeRandomWords(input int n);
      frameWords.delete();
      for (int i = 0; i < n; i++) frameWords.push_back($urandom);
   endtask

   // Send one frame with length field n (words from frameWords) and check
   // writes, timing of FLUSH/DONE or ERR, and that later bytes are ignored.
   task automatic runFrame(input int n, input bit throttle, input bit corrupt,
                           input bit doReset, input string tag);
      logic [7:0]  bytes[$];
      logic [31:0] expWords[$];
      logic [31:0] w;
      logic [7:0]  x;
      logic [15:0] nField;
      bit          expectErr;
      int          cnt;
      if (doReset) resetDut();
      nField = 16'(n);
      x = 8'h00;
      bytes.push_back(nField[15:8]);
      bytes.push_back(nField[7:0]);
      expectErr = (n > MAX_WORDS);
      if (!expectErr) begin
         for (int i = 0; i < n; i++) begin
            w = frameWords[i];
            expWords.push_back(w);
            for (int k = 3; k >= 0; k--) begin
               bytes.push_back(w[8*k +: 8]);
               x = x ^ w[8*k +: 8];
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         bytes.push_back(corrupt ? (x ^ 8'h01) : x);
         if (corrupt) expectErr = 1'b1;
`endif
      end
      for (int i = 0; i < bytes.size(); i++) begin
         applyStimulus(bytes[i], throttle && (i % 2 == 1), tag);
      end
      @(negedge clk);
      in_byte = 8'hA5;
      if (expectErr) begin
         checkOutput({tag, "_error"},   32'(error),     32'd1);
         checkOutput({tag, "_ready0"},  32'(in_ready),  32'd0);
         checkOutput({tag, "_cpurst0"}, 32'(cpu_rst_n), 32'd0);
         checkOutput({tag, "_done0"},   32'(done),      32'd0);
      end else begin
         checkOutput({tag, "_flush_ready"}, 32'(in_ready), 32'd0);
         checkOutput({tag, "_flush_done"},  32'(done),     32'd0);
         @(negedge clk);
         checkOutput({tag, "_done"},   32'(done),      32'd1);
         checkOutput({tag, "_cpurst"}, 32'(cpu_rst_n), 32'd1);
         checkOutput({tag, "_error0"}, 32'(error),     32'd0);
      end
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      checkOutput({tag, "_terminal"}, {30'd0, done, error},
                  expectErr ? 32'd1 : 32'd2);
      checkOutput({tag, "_nwrites"}, 32'(gotAddr.size()), 32'(expWords.size()));
      cnt = (gotAddr.size() < expWords.size()) ? gotAddr.size() : expWords.size();
      for (int i = 0; i < cnt; i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i), 32'(gotAddr[i]), 32'(4 * i));
         checkOutput($sformatf("%s_data%0d", tag, i), gotData[i], expWords[i]);
      end
   endtask

   initial begin
      int n;
      bit bad;
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;

      // Reset values.
      resetDut();
      #1;
      checkResetValues("reset");
      checkOutput("reset_ready", 32'(in_ready), 32'd1);

      // Basic load, in_valid held high, then throttled.
      frameWords = '{32'h20110003, 32'h200800FF};
      runFrame(2, 1'b0, 1'b0, 1'b1, "basic");
      runFrame(2, 1'b1, 1'b0, 1'b1, "throttled");

      // Oversize count and empty image.
      runFrame(MAX_WORDS + 1, 1'b0, 1'b0, 1'b1, "oversize");
      runFrame(16'hFFFF, 1'b1, 1'b0, 1'b1, "oversize_max");
      frameWords.delete();
      runFrame(0, 1'b0, 1'b0, 1'b1, "empty");

      // Mid-word reset, then a fresh frame without any further reset.
      resetDut();
      applyStimulus(8'h00, 1'b0, "mid");
      applyStimulus(8'h01, 1'b0, "mid");
      applyStimulus(8'h20, 1'b0, "mid");
      applyStimulus(8'h11, 1'b0, "mid");
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      checkResetValues("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("midreset_ready", 32'(in_ready), 32'd1);
      checkOutput("midreset_nowrite", 32'(gotAddr.size()), 32'd0);
      frameWords = '{32'h20110003};
      runFrame(1, 1'b0, 1'b0, 1'b0, "midreset_frame");

`ifdef IMEM_LOADER_CHECKSUM_EN
      frameWords = '{32'h20110003};
      runFrame(1, 1'b0, 1'b0, 1'b1, "csum_good");
      runFrame(1, 1'b0, 1'b1, 1'b1, "csum_bad");
`endif

      // Largest accepted image.
      makeRandomWords(MAX_WORDS);
      runFrame(MAX_WORDS, 1'b0, 1'b0, 1'b1, "maxwords");

      // Randomized frames.
      for (int f = 0; f < 10; f++) begin
         n   = $urandom_range(1, 12);
         bad = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         bad = ($urandom_range(0, 3) == 0);
`endif
         makeRandomWords(n);
         runFrame(n, 1'($urandom_range(0, 1)), bad, 1'b1, $sformatf("rand%0d", f));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
